// File: rtl/ex_alu_mdu_seq.sv
// EX-stage controller for RV32IM: decodes the instruction into a registered ALU code and
// executes M-extension ops locally (multi-cycle multiplier, radix-2 restoring divider).
module ex_alu_mdu_seq #(
  parameter int XLEN        = 32,
  parameter int ALU_CTL_W   = 5,
  parameter int MUL_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          inst_i,
  input  logic [XLEN-1:0]      rs1_val_i,
  input  logic [XLEN-1:0]      rs2_val_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ALU_CTL_W-1:0] alu_ctl_o,
  output logic                 is_mdu_o,
  output logic [XLEN-1:0]      mdu_result_o,
  output logic                 illegal_o
);

  localparam logic [ALU_CTL_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_XOR    = 5'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_OR     = 5'd3;
  localparam logic [ALU_CTL_W-1:0] ALU_AND    = 5'd4;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL    = 5'd5;
  localparam logic [ALU_CTL_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_LT     = 5'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_JAL    = 5'd8;
  localparam logic [ALU_CTL_W-1:0] ALU_SRA    = 5'd9;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT    = 5'd10;
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU   = 5'd11;
  localparam logic [ALU_CTL_W-1:0] ALU_MUL    = 5'd12;
  localparam logic [ALU_CTL_W-1:0] ALU_MULH   = 5'd13;
  localparam logic [ALU_CTL_W-1:0] ALU_MULHSU = 5'd14;
  localparam logic [ALU_CTL_W-1:0] ALU_MULHU  = 5'd15;
  localparam logic [ALU_CTL_W-1:0] ALU_DIV    = 5'd16;
  localparam logic [ALU_CTL_W-1:0] ALU_DIVU   = 5'd17;
  localparam logic [ALU_CTL_W-1:0] ALU_REM    = 5'd18;
  localparam logic [ALU_CTL_W-1:0] ALU_REMU   = 5'd19;

  localparam int DCW = $clog2(XLEN + 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(XLEN);
  localparam int MUL_LAST_I = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam logic [7:0] MUL_LAST = 8'(MUL_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Returns {illegal, alu_ctl}; undecoded encodings fall back to ADD with illegal set.
  function automatic logic [ALU_CTL_W:0] decode(input logic [31:0] ins);
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [ALU_CTL_W:0] r;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    r   = {1'b1, ALU_ADD};
    case (opc)
      7'b0110011: begin
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  r = {1'b0, ALU_ADD};
              3'b001:  r = {1'b0, ALU_SLL};
              3'b010:  r = {1'b0, ALU_SLT};
              3'b011:  r = {1'b0, ALU_SLTU};
              3'b100:  r = {1'b0, ALU_XOR};
              3'b101:  r = {1'b0, ALU_SRL};
              3'b110:  r = {1'b0, ALU_OR};
              3'b111:  r = {1'b0, ALU_AND};
              default: r = {1'b1, ALU_ADD};
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  r = {1'b0, ALU_SUB};
              3'b101:  r = {1'b0, ALU_SRA};
              default: r = {1'b1, ALU_ADD};
            endcase
          end
          7'b0000001: r = {1'b0, ALU_MUL + {2'b00, f3}};
          default:    r = {1'b1, ALU_ADD};
        endcase
      end
      7'b1100011: begin
        case (f3)
          3'b000:  r = {1'b0, ALU_SUB};
          3'b100:  r = {1'b0, ALU_LT};
          default: r = {1'b1, ALU_ADD};
        endcase
      end
      7'b1101111: r = {1'b0, ALU_JAL};
      7'b0010011: r = (f3 == 3'b000) ? {1'b0, ALU_ADD} : {1'b1, ALU_ADD};
      7'b0000011: r = (f3 == 3'b010) ? {1'b0, ALU_ADD} : {1'b1, ALU_ADD};
      7'b0100011: r = (f3 == 3'b010) ? {1'b0, ALU_ADD} : {1'b1, ALU_ADD};
      default:    r = {1'b1, ALU_ADD};
    endcase
    return r;
  endfunction

  // Sign-extends per operand signedness so one 2*XLEN product serves all four MUL variants.
  function automatic logic [XLEN-1:0] mul_res(input logic [ALU_CTL_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    logic [2*XLEN-1:0] p;
    ea = {{XLEN{a[XLEN-1] & ((op == ALU_MULH) || (op == ALU_MULHSU))}}, a};
    eb = {{XLEN{b[XLEN-1] & (op == ALU_MULH)}}, b};
    p  = ea * eb;
    if (op == ALU_MUL) begin
      return p[XLEN-1:0];
    end else begin
      return p[2*XLEN-1:XLEN];
    end
  endfunction

  state_e                state_q, state_d;
  logic [7:0]            mcnt_q, mcnt_d;
  logic [DCW-1:0]        dcnt_q, dcnt_d;
  logic [ALU_CTL_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;
  logic [ALU_CTL_W-1:0]  ctl_q, ctl_d;
  logic                  mdu_q, mdu_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic                  ill_q, ill_d;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  dec_ill_s;
  logic [ALU_CTL_W-1:0]  dec_ctl_s;
  logic                  dec_mul_s;
  logic                  dec_div_s;
  logic                  dec_sgn_s;
  logic                  dec_rem_s;
  logic                  ovf_s;
  logic [XLEN-1:0]       abs_a_s;
  logic [XLEN-1:0]       abs_b_s;
  logic [XLEN:0]         div_shift_s;
  logic [XLEN:0]         div_diff_s;
  logic [XLEN-1:0]       quot_fix_s;
  logic [XLEN-1:0]       rem_fix_s;

  assign in_ready_s = ~flush_i & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i));
  assign accept_s   = in_valid_i & in_ready_s;

  assign {dec_ill_s, dec_ctl_s} = decode(inst_i);
  assign dec_mul_s = (dec_ctl_s >= ALU_MUL) && (dec_ctl_s <= ALU_MULHU);
  assign dec_div_s = (dec_ctl_s >= ALU_DIV) && (dec_ctl_s <= ALU_REMU);
  assign dec_sgn_s = (dec_ctl_s == ALU_DIV) || (dec_ctl_s == ALU_REM);
  assign dec_rem_s = (dec_ctl_s == ALU_REM) || (dec_ctl_s == ALU_REMU);
  assign ovf_s     = dec_sgn_s && (rs1_val_i == {1'b1, {(XLEN-1){1'b0}}})
                               && (rs2_val_i == {XLEN{1'b1}});
  assign abs_a_s   = (dec_sgn_s & rs1_val_i[XLEN-1]) ? ({XLEN{1'b0}} - rs1_val_i) : rs1_val_i;
  assign abs_b_s   = (dec_sgn_s & rs2_val_i[XLEN-1]) ? ({XLEN{1'b0}} - rs2_val_i) : rs2_val_i;

  // One restoring step: a_q shifts the dividend out and the quotient bits in.
  assign div_shift_s = {rem_q, a_q[XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_q};
  assign quot_fix_s  = qneg_q ? ({XLEN{1'b0}} - a_q) : a_q;
  assign rem_fix_s   = rneg_q ? ({XLEN{1'b0}} - rem_q) : rem_q;

  // Next-state and datapath update; flush outranks everything, then a new accept.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    dcnt_d  = dcnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ctl_d   = ctl_q;
    mdu_d   = mdu_q;
    res_d   = res_q;
    ill_d   = ill_q;
    if (flush_i) begin
      state_d = S_IDLE;
      mcnt_d  = 8'd0;
      dcnt_d  = {DCW{1'b0}};
    end else if (accept_s) begin
      ctl_d  = dec_ctl_s;
      ill_d  = dec_ill_s;
      op_d   = dec_ctl_s;
      mdu_d  = dec_mul_s | dec_div_s;
      res_d  = {XLEN{1'b0}};
      mcnt_d = 8'd0;
      dcnt_d = {DCW{1'b0}};
      if (dec_mul_s) begin
        if (MUL_LATENCY == 1) begin
          res_d   = mul_res(dec_ctl_s, rs1_val_i, rs2_val_i);
          state_d = S_DONE;
        end else begin
          a_d     = rs1_val_i;
          b_d     = rs2_val_i;
          state_d = S_MUL;
        end
      end else if (dec_div_s) begin
        if (rs2_val_i == {XLEN{1'b0}}) begin
          res_d   = dec_rem_s ? rs1_val_i : {XLEN{1'b1}};
          state_d = S_DONE;
        end else if (ovf_s) begin
          res_d   = dec_rem_s ? {XLEN{1'b0}} : rs1_val_i;
          state_d = S_DONE;
        end else begin
          a_d     = abs_a_s;
          b_d     = abs_b_s;
          rem_d   = {XLEN{1'b0}};
          qneg_d  = dec_sgn_s & (rs1_val_i[XLEN-1] ^ rs2_val_i[XLEN-1]);
          rneg_d  = dec_sgn_s & rs1_val_i[XLEN-1];
          state_d = S_DIV;
        end
      end else begin
        state_d = S_DONE;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          if (mcnt_q == MUL_LAST) begin
            res_d   = mul_res(op_q, a_q, b_q);
            mcnt_d  = 8'd0;
            state_d = S_DONE;
          end else begin
            mcnt_d = mcnt_q + 8'd1;
          end
        end
        S_DIV: begin
          if (dcnt_q == DIV_LAST) begin
            res_d   = ((op_q == ALU_REM) || (op_q == ALU_REMU)) ? rem_fix_s : quot_fix_s;
            dcnt_d  = {DCW{1'b0}};
            state_d = S_DONE;
          end else if (!div_diff_s[XLEN]) begin
            rem_d  = div_diff_s[XLEN-1:0];
            a_d    = {a_q[XLEN-2:0], 1'b1};
            dcnt_d = dcnt_q + {{(DCW-1){1'b0}}, 1'b1};
          end else begin
            rem_d  = div_shift_s[XLEN-1:0];
            a_d    = {a_q[XLEN-2:0], 1'b0};
            dcnt_d = dcnt_q + {{(DCW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counters, operand/result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mcnt_q  <= 8'd0;
      dcnt_q  <= {DCW{1'b0}};
      op_q    <= ALU_ADD;
      a_q     <= {XLEN{1'b0}};
      b_q     <= {XLEN{1'b0}};
      rem_q   <= {XLEN{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ctl_q   <= ALU_ADD;
      mdu_q   <= 1'b0;
      res_q   <= {XLEN{1'b0}};
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      dcnt_q  <= dcnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ctl_q   <= ctl_d;
      mdu_q   <= mdu_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready_o   = in_ready_s;
  assign out_valid_o  = (state_q == S_DONE);
  assign alu_ctl_o    = ctl_q;
  assign is_mdu_o     = mdu_q;
  assign mdu_result_o = res_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_ex_alu_mdu_seq.sv
// Scoreboard bench for ex_alu_mdu_seq: expectations queued at accept, compared on output.
module tb_ex_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  alu_ctl;
  logic        is_mdu;
  logic [31:0] mdu_result;
  logic        illegal;

  ex_alu_mdu_seq #(.XLEN(32), .ALU_CTL_W(5), .MUL_LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst),
    .rs1_val_i(rs1), .rs2_val_i(rs2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_ctl_o(alu_ctl), .is_mdu_o(is_mdu), .mdu_result_o(mdu_result), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctl;
    logic        mdu;
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_S = 7'b0100000;
  localparam logic [6:0] F7_M = 7'b0000001;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 5'd3, 5'd2, f3, 5'd1, opc};
  endfunction

  function automatic exp_t mk(input logic [4:0] c, input logic m, input logic [31:0] r,
                              input logic il);
    exp_t e;
    e.ctl = c; e.mdu = m; e.res = r; e.ill = il;
    return e;
  endfunction

  // Reference M-extension results from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    ia = a; ib = b;
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin sa = longint'(ia); sb = longint'(ib); p = sa * sb; return p[63:32]; end
      3'd2: begin sa = longint'(ia); sb = longint'({32'd0, b}); p = sa * sb; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Output monitor: every completed handshake pops and checks the oldest expectation.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got out_valid ctl=%0d res=%h, required no output",
                 alu_ctl, mdu_result);
      end else begin
        mon_e = sbq.pop_front();
        if (alu_ctl !== mon_e.ctl || is_mdu !== mon_e.mdu || illegal !== mon_e.ill ||
            (mon_e.mdu && mdu_result !== mon_e.res)) begin
          n_err++;
          $display("FAIL sb_result: got ctl=%0d mdu=%b ill=%b res=%h, required ctl=%0d mdu=%b ill=%b res=%h",
                   alu_ctl, is_mdu, illegal, mdu_result, mon_e.ctl, mon_e.mdu, mon_e.ill, mon_e.res);
        end
      end
    end
  end

  // Drive one op at a negedge, wait for acceptance, then scramble the operand inputs.
  task automatic issue(input logic [31:0] i_inst, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input exp_t e, output int waited);
    inst = i_inst; rs1 = a; rs2 = b; in_valid = 1'b1; waited = 0;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      return;
    end
    if (push) sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({out_valid, alu_ctl, is_mdu, mdu_result, illegal} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b ctl=%0d mdu=%b res=%h ill=%b, required all 0",
               out_valid, alu_ctl, is_mdu, mdu_result, illegal);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [31:0] ti [19];
    logic [4:0]  tc [19];
    logic        tl [19];
    int w;
    ti[0]  = 32'h003100B3;                tc[0]  = 5'd0;  tl[0]  = 1'b0;
    ti[1]  = enc(F7_S, 3'd0, OP_R);       tc[1]  = 5'd1;  tl[1]  = 1'b0;
    ti[2]  = enc(F7_0, 3'd4, OP_R);       tc[2]  = 5'd2;  tl[2]  = 1'b0;
    ti[3]  = enc(F7_0, 3'd6, OP_R);       tc[3]  = 5'd3;  tl[3]  = 1'b0;
    ti[4]  = enc(F7_0, 3'd7, OP_R);       tc[4]  = 5'd4;  tl[4]  = 1'b0;
    ti[5]  = enc(F7_0, 3'd1, OP_R);       tc[5]  = 5'd5;  tl[5]  = 1'b0;
    ti[6]  = enc(F7_0, 3'd5, OP_R);       tc[6]  = 5'd6;  tl[6]  = 1'b0;
    ti[7]  = enc(F7_S, 3'd5, OP_R);       tc[7]  = 5'd9;  tl[7]  = 1'b0;
    ti[8]  = enc(F7_0, 3'd2, OP_R);       tc[8]  = 5'd10; tl[8]  = 1'b0;
    ti[9]  = enc(F7_0, 3'd3, OP_R);       tc[9]  = 5'd11; tl[9]  = 1'b0;
    ti[10] = enc(F7_0, 3'd0, 7'b1100011); tc[10] = 5'd1;  tl[10] = 1'b0;
    ti[11] = enc(F7_0, 3'd4, 7'b1100011); tc[11] = 5'd7;  tl[11] = 1'b0;
    ti[12] = enc(F7_0, 3'd0, 7'b1101111); tc[12] = 5'd8;  tl[12] = 1'b0;
    ti[13] = enc(F7_0, 3'd0, 7'b0010011); tc[13] = 5'd0;  tl[13] = 1'b0;
    ti[14] = enc(F7_0, 3'd2, 7'b0000011); tc[14] = 5'd0;  tl[14] = 1'b0;
    ti[15] = enc(F7_0, 3'd2, 7'b0100011); tc[15] = 5'd0;  tl[15] = 1'b0;
    ti[16] = enc(F7_0, 3'd1, 7'b1100011); tc[16] = 5'd0;  tl[16] = 1'b1;
    ti[17] = 32'h0000007F;                tc[17] = 5'd0;  tl[17] = 1'b1;
    ti[18] = enc(F7_S, 3'd1, OP_R);       tc[18] = 5'd0;  tl[18] = 1'b1;
    for (int i = 0; i < 19; i++) begin
      issue(ti[i], $urandom, $urandom, 1'b1, mk(tc[i], 1'b0, 32'd0, tl[i]), w);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || alu_ctl !== tc[i] || is_mdu !== 1'b0 || illegal !== tl[i]) begin
        n_err++;
        $display("FAIL decode_%0d: got v=%b ctl=%0d mdu=%b ill=%b, required v=1 ctl=%0d mdu=0 ill=%b",
                 i, out_valid, alu_ctl, is_mdu, illegal, tc[i], tl[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2, w3;
    issue(32'h003100B3, 32'd1, 32'd2, 1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0), w1);
    issue(32'h003100B3, 32'd3, 32'd4, 1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0), w2);
    issue(32'h003100B3, 32'd5, 32'd6, 1'b1, mk(5'd0, 1'b0, 32'd0, 1'b0), w3);
    #1;
    n_cmp++;
    if (w2 !== 0 || w3 !== 0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back: got waits %0d/%0d out_valid=%b, required 0/0 and 1", w2, w3, out_valid);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3s [4];
    logic [31:0] exps [4];
    logic [31:0] a, b;
    logic [2:0]  f;
    int w;
    f3s[0] = 3'd1; exps[0] = 32'hFFFF_FFFF;
    f3s[1] = 3'd3; exps[1] = 32'h0000_0002;
    f3s[2] = 3'd0; exps[2] = 32'hFFFF_FFFD;
    f3s[3] = 3'd2; exps[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      issue(enc(F7_M, f3s[i], OP_R), 32'hFFFF_FFFF, 32'd3, 1'b1,
            mk(5'd12 + {2'b00, f3s[i]}, 1'b1, exps[i], 1'b0), w);
      if (i == 0) begin
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL mul_early: got out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || mdu_result !== 32'hFFFF_FFFF) begin
          n_err++;
          $display("FAIL mul_latency: got v=%b res=%h at 2 cycles, required 1/ffffffff", out_valid, mdu_result);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; f = 3'(i % 4);
      issue(enc(F7_M, f, OP_R), a, b, 1'b1, mk(5'd12 + {2'b00, f}, 1'b1, model(f, a, b), 1'b0), w);
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    logic [2:0]  f;
    int w, n, busy_bad;
    issue(enc(F7_M, 3'd4, OP_R), 32'hFFFF_FFF9, 32'd2, 1'b1, mk(5'd16, 1'b1, 32'hFFFF_FFFD, 1'b0), w);
    n = 1; busy_bad = 0;
    #1;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(negedge clk); #1; n++;
    end
    n_cmp++;
    if (n !== 34 || busy_bad !== 0) begin
      n_err++;
      $display("FAIL div_latency: got %0d cycles, %0d busy cycles with in_ready=1, required 34 and 0", n, busy_bad);
    end
    issue(enc(F7_M, 3'd6, OP_R), 32'hFFFF_FFF9, 32'd2, 1'b1, mk(5'd18, 1'b1, 32'hFFFF_FFFF, 1'b0), w);
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom >> $urandom_range(0, 31); f = 3'(4 + (i % 4));
      issue(enc(F7_M, f, OP_R), a, b, 1'b1, mk(5'd12 + {2'b00, f}, 1'b1, model(f, a, b), 1'b0), w);
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f3s [6];
    logic [31:0] as [6];
    logic [31:0] bs [6];
    logic [31:0] exps [6];
    int w;
    f3s[0] = 3'd5; as[0] = 32'd5;          bs[0] = 32'd0;          exps[0] = 32'hFFFF_FFFF;
    f3s[1] = 3'd7; as[1] = 32'd5;          bs[1] = 32'd0;          exps[1] = 32'd5;
    f3s[2] = 3'd4; as[2] = 32'h8000_0000;  bs[2] = 32'hFFFF_FFFF;  exps[2] = 32'h8000_0000;
    f3s[3] = 3'd6; as[3] = 32'h8000_0000;  bs[3] = 32'hFFFF_FFFF;  exps[3] = 32'd0;
    f3s[4] = 3'd4; as[4] = 32'd7;          bs[4] = 32'd0;          exps[4] = 32'hFFFF_FFFF;
    f3s[5] = 3'd6; as[5] = 32'hFFFF_FFF9;  bs[5] = 32'd0;          exps[5] = 32'hFFFF_FFF9;
    for (int i = 0; i < 6; i++) begin
      issue(enc(F7_M, f3s[i], OP_R), as[i], bs[i], 1'b1,
            mk(5'd12 + {2'b00, f3s[i]}, 1'b1, exps[i], 1'b0), w);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || mdu_result !== exps[i]) begin
        n_err++;
        $display("FAIL div_special_%0d: got v=%b res=%h after 1 cycle, required 1/%h",
                 i, out_valid, mdu_result, exps[i]);
      end
    end
  endtask

  task automatic test_stall();
    int w, bad;
    idle(3);
    out_ready = 1'b0;
    issue(enc(F7_0, 3'd4, OP_R), 32'd1, 32'd2, 1'b1, mk(5'd2, 1'b0, 32'd0, 1'b0), w);
    inst = enc(F7_S, 3'd0, OP_R); in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid !== 1'b1 || alu_ctl !== 5'd2 || illegal !== 1'b0 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d unstable cycles, required 0 (v=%b ctl=%0d in_ready=%b)",
               bad, out_valid, alu_ctl, in_ready);
    end
    out_ready = 1'b1;
    sbq.push_back(mk(5'd1, 1'b0, 32'd0, 1'b0));
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: got in_ready=%b with out_ready=1 in DONE, required 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int w, bad;
    idle(3);
    issue(enc(F7_M, 3'd4, OP_R), 32'd1000, 32'd7, 1'b0, mk(5'd0, 1'b0, 32'd0, 1'b0), w);
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; inst = 32'h003100B3;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: got in_ready=%b during flush, required 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got in_ready=%b out_valid=%b after flush, required 1/0", in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL flush_no_output: got out_valid in %0d cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_mul();
    int w;
    idle(3);
    issue(enc(F7_M, 3'd0, OP_R), 32'd5, 32'd7, 1'b0, mk(5'd0, 1'b0, 32'd0, 1'b0), w);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, alu_ctl, is_mdu, mdu_result, illegal} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_mid_mul: got v=%b ctl=%0d mdu=%b res=%h ill=%b, required all 0",
               out_valid, alu_ctl, is_mdu, mdu_result, illegal);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: got in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    issue(enc(F7_0, 3'd6, OP_R), 32'd9, 32'd9, 1'b1, mk(5'd3, 1'b0, 32'd0, 1'b0), w);
  endtask

  initial begin
    int budget;
    test_reset();
    test_decode();
    test_back_to_back();
    test_mul();
    test_div();
    test_div_special();
    test_stall();
    test_flush();
    test_reset_mid_mul();
    budget = 0;
    while (sbq.size() != 0 && budget < 100) begin
      @(negedge clk); budget++;
    end
    #3;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
